// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris input path.
//   - HID keycodes recognised by the command generator
//   - Command-generator FSM state encoding
//   - Pulse-vector bit positions and small helper functions that map a
//     keycode onto its output pulse and the state entered on a new press
package tetris_pkg;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    // Bit positions inside the 5-bit pulse vector.
    localparam int P_LEFT  = 4;
    localparam int P_RIGHT = 3;
    localparam int P_ROT   = 2;
    localparam int P_SOFT  = 1;
    localparam int P_HARD  = 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DELAY  = 3'd1,
        REPEAT = 3'd2,
        SDROP  = 3'd3,
        HOLD   = 3'd4
    } state_t;

    function automatic logic key_is_mapped(input logic [7:0] key);
        return (key == KEY_A) || (key == KEY_D) || (key == KEY_W) ||
               (key == KEY_S) || (key == KEY_SPACE);
    endfunction

    // One-hot pulse for a mapped key; zero for anything else.
    function automatic logic [4:0] key_to_pulse(input logic [7:0] key);
        logic [4:0] p;
        p = 5'b0;
        case (key)
            KEY_A:     p[P_LEFT]  = 1'b1;
            KEY_D:     p[P_RIGHT] = 1'b1;
            KEY_W:     p[P_ROT]   = 1'b1;
            KEY_S:     p[P_SOFT]  = 1'b1;
            KEY_SPACE: p[P_HARD]  = 1'b1;
            default:   p = 5'b0;
        endcase
        return p;
    endfunction

    // State entered on a fresh press of a mapped key.
    function automatic state_t key_to_state(input logic [7:0] key);
        state_t s;
        case (key)
            KEY_A, KEY_D:     s = DELAY;
            KEY_S:            s = SDROP;
            KEY_W, KEY_SPACE: s = HOLD;
            default:          s = IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/key_cmd_gen.sv
// Turns the raw HID keycode into one-cycle game command pulses.
//
// State table:
//   IDLE   | no mapped key held, nothing pending
//   DELAY  | A/D held, waiting out the auto-shift delay before first repeat
//   REPEAT | A/D held past the delay, pulsing every ARR_PERIOD cycles
//   SDROP  | S held, pulsing every SDROP_PERIOD cycles
//   HOLD   | W/space held, single shot already issued
//
// Ports:
//   frame_clk  in   sole clock, rising edge
//   Reset      in   synchronous, active-high
//   keycode    in   8-bit HID keycode, 0x00 = no key
//   move_left  out  pulse, key A
//   move_right out  pulse, key D
//   rotate     out  pulse, key W
//   soft_drop  out  pulse, key S
//   hard_drop  out  pulse, space
module key_cmd_gen
    import tetris_pkg::*;
#(
    parameter int DAS_DELAY    = 10,
    parameter int ARR_PERIOD   = 2,
    parameter int SDROP_PERIOD = 3
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic       move_left,
    output logic       move_right,
    output logic       rotate,
    output logic       soft_drop,
    output logic       hard_drop
);

    localparam int MAX_P_AD = (DAS_DELAY > ARR_PERIOD) ? DAS_DELAY : ARR_PERIOD;
    localparam int MAX_P    = (MAX_P_AD > SDROP_PERIOD) ? MAX_P_AD : SDROP_PERIOD;
    localparam int CNT_W    = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] DAS_TC   = CNT_W'(DAS_DELAY - 1);
    localparam logic [CNT_W-1:0] ARR_TC   = CNT_W'(ARR_PERIOD - 1);
    localparam logic [CNT_W-1:0] SDROP_TC = CNT_W'(SDROP_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_last_key;
    logic [4:0]       r_pulse;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [7:0]       w_last_key_nxt;
    logic [4:0]       w_pulse_nxt;
    logic             w_mapped;
    logic             w_new_press;

    assign w_mapped    = key_is_mapped(keycode);
    assign w_new_press = w_mapped && (keycode != r_last_key);
    // Saturate so a stuck counter can never wrap round to a terminal count.
    assign w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_last_key <= KEY_NONE;
            r_pulse    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_last_key <= w_last_key_nxt;
            r_pulse    <= w_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_last_key_nxt = r_last_key;
        w_pulse_nxt    = '0;

        if (!w_mapped) begin
            // Release or unmapped key: drop everything, including a due repeat.
            w_state_nxt    = IDLE;
            w_cnt_nxt      = '0;
            w_last_key_nxt = KEY_NONE;
        end else if (w_new_press) begin
            // Also covers a direct key switch: timers restart with no idle gap.
            w_state_nxt    = key_to_state(keycode);
            w_cnt_nxt      = '0;
            w_last_key_nxt = keycode;
            w_pulse_nxt    = key_to_pulse(keycode);
        end else begin
            case (r_state)
                DELAY: begin
                    if (r_cnt == DAS_TC) begin
                        w_pulse_nxt = key_to_pulse(r_last_key);
                        w_cnt_nxt   = '0;
                        w_state_nxt = REPEAT;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                REPEAT: begin
                    if (r_cnt == ARR_TC) begin
                        w_pulse_nxt = key_to_pulse(r_last_key);
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                SDROP: begin
                    if (r_cnt == SDROP_TC) begin
                        w_pulse_nxt = key_to_pulse(r_last_key);
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                HOLD: begin
                    w_cnt_nxt = '0;
                end
                default: begin
                    w_state_nxt    = IDLE;
                    w_cnt_nxt      = '0;
                    w_last_key_nxt = KEY_NONE;
                end
            endcase
        end
    end

    assign move_left  = r_pulse[P_LEFT];
    assign move_right = r_pulse[P_RIGHT];
    assign rotate     = r_pulse[P_ROT];
    assign soft_drop  = r_pulse[P_SOFT];
    assign hard_drop  = r_pulse[P_HARD];

endmodule

// File: tb/tb_key_cmd_gen.sv
// Directed bench for key_cmd_gen with default parameters.
// Output vector order: {move_left, move_right, rotate, soft_drop, hard_drop}.
module tb_key_cmd_gen;

    logic       frame_clk;
    logic       Reset;
    logic [7:0] keycode;
    logic       move_left, move_right, rotate, soft_drop, hard_drop;

    key_cmd_gen dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .keycode    (keycode),
        .move_left  (move_left),
        .move_right (move_right),
        .rotate     (rotate),
        .soft_drop  (soft_drop),
        .hard_drop  (hard_drop)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    localparam logic [4:0] N = 5'b00000;
    localparam logic [4:0] L = 5'b10000;
    localparam logic [4:0] R = 5'b01000;
    localparam logic [4:0] W = 5'b00100;
    localparam logic [4:0] S = 5'b00010;
    localparam logic [4:0] H = 5'b00001;

    typedef struct {
        logic       rst;
        logic [7:0] key;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_tests;
    int   n_fail;

    function automatic logic [4:0] outs();
        return {move_left, move_right, rotate, soft_drop, hard_drop};
    endfunction

    task automatic add(input logic rst, input logic [7:0] key, input logic [4:0] exp, input int cnt);
        vec_t v;
        v.rst = rst;
        v.key = key;
        v.exp = exp;
        for (int i = 0; i < cnt; i++) vecs.push_back(v);
    endtask

    // Apply inputs, clock once, sample just after the edge.
    task automatic step(input logic rst, input logic [7:0] key);
        Reset   = rst;
        keycode = key;
        @(posedge frame_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        int pulses;
        n_tests = 0;
        n_fail  = 0;
        Reset   = 1'b1;
        keycode = 8'h00;

        // Reset held with A down, then A counts as a fresh press.
        add(1, 8'h04, N, 5);
        add(0, 8'h04, L, 1);
        add(0, 8'h00, N, 3);
        // A held 15 edges: pulses at 0, 10, 12, 14; nothing after release.
        add(0, 8'h04, L, 1);
        add(0, 8'h04, N, 9);
        add(0, 8'h04, L, 1);
        add(0, 8'h04, N, 1);
        add(0, 8'h04, L, 1);
        add(0, 8'h04, N, 1);
        add(0, 8'h04, L, 1);
        add(0, 8'h00, N, 5);
        // Short D taps never reach the auto-shift delay.
        for (int k = 0; k < 2; k++) begin
            add(0, 8'h07, R, 1);
            add(0, 8'h07, N, 4);
            add(0, 8'h00, N, 50);
        end
        // A then direct switch to D: immediate R, delay restarted.
        add(0, 8'h04, L, 1);
        add(0, 8'h04, N, 3);
        add(0, 8'h07, R, 1);
        add(0, 8'h07, N, 9);
        add(0, 8'h07, R, 1);
        add(0, 8'h07, N, 1);
        add(0, 8'h07, R, 1);
        add(0, 8'h00, N, 2);
        // Single shots: W then space, each held 30 cycles.
        add(0, 8'h1A, W, 1);
        add(0, 8'h1A, N, 29);
        add(0, 8'h2C, H, 1);
        add(0, 8'h2C, N, 29);
        // S held 9 cycles: pulses at 0, 3, 6.
        add(0, 8'h16, S, 1);
        add(0, 8'h16, N, 2);
        add(0, 8'h16, S, 1);
        add(0, 8'h16, N, 2);
        add(0, 8'h16, S, 1);
        add(0, 8'h16, N, 2);
        add(0, 8'h00, N, 2);
        // Unmapped key produces nothing.
        add(0, 8'h05, N, 20);
        // W interrupted by an unmapped key, then W again: fresh press.
        add(0, 8'h1A, W, 1);
        add(0, 8'h05, N, 1);
        add(0, 8'h1A, W, 1);
        add(0, 8'h00, N, 1);
        // Reset and new press on the same edge: reset wins.
        add(1, 8'h04, N, 1);
        add(0, 8'h04, L, 1);
        add(0, 8'h00, N, 2);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].key);
            check($sformatf("vec[%0d] rst=%0b key=%02h", i, vecs[i].rst, vecs[i].key),
                  outs(), vecs[i].exp);
        end

        // Reset in the REPEAT phase aborts the hold.
        pulses = 0;
        for (int i = 0; i < 13; i++) begin
            step(0, 8'h04);
            if (move_left) pulses++;
        end
        check("repeat_pulse_at_12", outs(), L);
        n_tests++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL repeat_count: got %0d expected 3", pulses);
        end
        step(1, 8'h04);
        check("reset_stops_repeat", outs(), N);
        step(1, 8'h04);
        check("reset_held", outs(), N);
        step(0, 8'h04);
        check("fresh_press_after_reset", outs(), L);
        step(0, 8'h04);
        check("no_repeat_after_fresh", outs(), N);
        step(0, 8'h00);
        check("release_idle", outs(), N);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
